// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: active-low {g..a} segment
// patterns and the two-state scan FSM encoding.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0100111;
    localparam logic [6:0] SEG_B     = 7'b0110011;
    localparam logic [6:0] SEG_C     = 7'b0011101;
    localparam logic [6:0] SEG_D     = 7'b0010110;
    localparam logic [6:0] SEG_E     = 7'b0000111;
    localparam logic [6:0] SEG_F     = 7'b1111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [0:0] ST_BLANK  = 1'b0;
    localparam logic [0:0] ST_SHOW   = 1'b1;

endpackage

// File: rtl/ssd_seg_enc.sv
// Combinational hex nibble to active-low {g..a} cathode pattern; F renders blank.
module ssd_seg_enc
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nib)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with anti-ghost blank gap and
// tear-free frame commit. Define SSD_SCAN_LZB_EN to enable leading-zero blanking.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                    ssd_scan_ctrl_port_clk,
    input  logic                    ssd_scan_ctrl_port_rst_n,
    input  logic [4*NUM_DIGITS-1:0] ssd_scan_ctrl_port_data,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_ctrl_port_dp,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_ctrl_port_en,
    input  logic                    ssd_scan_ctrl_port_load,
    output logic [NUM_DIGITS-1:0]   ssd_scan_ctrl_port_an,
    output logic [6:0]              ssd_scan_ctrl_port_cc,
    output logic                    ssd_scan_ctrl_port_dp_out,
    output logic                    ssd_scan_ctrl_port_frame,
    output logic                    ssd_scan_ctrl_port_pending
);

    localparam int unsigned DIGIT_TICKS = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int unsigned CNT_W       = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int unsigned IDX_W       = $clog2(NUM_DIGITS);

    logic                           clk;
    logic                           rst_n;
    logic [NUM_DIGITS-1:0][3:0]     data_in_c;

    logic [0:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]     data_act_q, data_act_d, data_stg_q, data_stg_d;
    logic [NUM_DIGITS-1:0]          dp_act_q, dp_act_d, dp_stg_q, dp_stg_d;
    logic [NUM_DIGITS-1:0]          en_act_q, en_act_d, en_stg_q, en_stg_d;
    logic                           pending_q, pending_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [6:0]                     cc_q, cc_d;
    logic                           dp_out_q, dp_out_d;
    logic                           frame_q, frame_d;

    logic                           slot_end_c;
    logic                           wrap_c;
    logic                           digit_lit_c;
    logic [6:0]                     seg_c;

    assign clk       = ssd_scan_ctrl_port_clk;
    assign rst_n     = ssd_scan_ctrl_port_rst_n;
    assign data_in_c = ssd_scan_ctrl_port_data;

    assign slot_end_c = (state_q == ST_SHOW) && (cnt_q == CNT_W'(DIGIT_TICKS - 1));
    assign wrap_c     = slot_end_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef SSD_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_dark_c;
    logic                  zero_run_c;

    // A digit above 0 goes dark when it and every higher digit are a bare zero.
    always_comb begin
        lzb_dark_c = '0;
        zero_run_c = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run_c    = zero_run_c & (data_act_q[i] == 4'h0) & ~dp_act_q[i];
            lzb_dark_c[i] = zero_run_c;
        end
    end

    assign digit_lit_c = en_act_q[idx_q] & ~lzb_dark_c[idx_q];
`else
    assign digit_lit_c = en_act_q[idx_q];
`endif

    ssd_seg_enc u_seg_enc (
        .nib   (data_act_q[idx_q]),
        .seg_c (seg_c)
    );

    // Scan FSM, frame commit and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        data_act_d = data_act_q;
        dp_act_d   = dp_act_q;
        en_act_d   = en_act_q;
        data_stg_d = data_stg_q;
        dp_stg_d   = dp_stg_q;
        en_stg_d   = en_stg_q;
        pending_d  = pending_q;
        an_d       = '1;
        cc_d       = SEG_BLANK;
        dp_out_d   = 1'b1;
        frame_d    = wrap_c;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (slot_end_c) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = wrap_c ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // Active frame only changes at the wrap; a load in that cycle bypasses staging.
        if (wrap_c) begin
            pending_d = 1'b0;
            if (ssd_scan_ctrl_port_load) begin
                data_act_d = data_in_c;
                dp_act_d   = ssd_scan_ctrl_port_dp;
                en_act_d   = ssd_scan_ctrl_port_en;
            end else if (pending_q) begin
                data_act_d = data_stg_q;
                dp_act_d   = dp_stg_q;
                en_act_d   = en_stg_q;
            end
        end else if (ssd_scan_ctrl_port_load) begin
            data_stg_d = data_in_c;
            dp_stg_d   = ssd_scan_ctrl_port_dp;
            en_stg_d   = ssd_scan_ctrl_port_en;
            pending_d  = 1'b1;
        end

        if ((state_q == ST_SHOW) && digit_lit_c) begin
            an_d[idx_q] = 1'b0;
            cc_d        = seg_c;
            dp_out_d    = ~dp_act_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_act_q <= '0;
            dp_act_q   <= '0;
            en_act_q   <= '0;
            data_stg_q <= '0;
            dp_stg_q   <= '0;
            en_stg_q   <= '0;
            pending_q  <= 1'b0;
            an_q       <= '1;
            cc_q       <= SEG_BLANK;
            dp_out_q   <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_act_q <= data_act_d;
            dp_act_q   <= dp_act_d;
            en_act_q   <= en_act_d;
            data_stg_q <= data_stg_d;
            dp_stg_q   <= dp_stg_d;
            en_stg_q   <= en_stg_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            cc_q       <= cc_d;
            dp_out_q   <= dp_out_d;
            frame_q    <= frame_d;
        end
    end

    assign ssd_scan_ctrl_port_an      = an_q;
    assign ssd_scan_ctrl_port_cc      = cc_q;
    assign ssd_scan_ctrl_port_dp_out  = dp_out_q;
    assign ssd_scan_ctrl_port_frame   = frame_q;
    assign ssd_scan_ctrl_port_pending = pending_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with small timing parameters (10-cycle slots, 2-cycle blank).
// Define SSD_SCAN_LZB_EN for both RTL and bench to check leading-zero blanking.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        load;
    logic [7:0]  an;
    logic [6:0]  cc;
    logic        dp_out;
    logic        frame;
    logic        pending;

    int checks = 0;
    int errors = 0;

    ssd_scan_ctrl #(
        .CLK_HZ       (800),
        .REFRESH_HZ   (10),
        .NUM_DIGITS   (8),
        .BLANK_CYCLES (2)
    ) dut (
        .ssd_scan_ctrl_port_clk     (clk),
        .ssd_scan_ctrl_port_rst_n   (rst_n),
        .ssd_scan_ctrl_port_data    (data),
        .ssd_scan_ctrl_port_dp      (dp),
        .ssd_scan_ctrl_port_en      (en),
        .ssd_scan_ctrl_port_load    (load),
        .ssd_scan_ctrl_port_an      (an),
        .ssd_scan_ctrl_port_cc      (cc),
        .ssd_scan_ctrl_port_dp_out  (dp_out),
        .ssd_scan_ctrl_port_frame   (frame),
        .ssd_scan_ctrl_port_pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0011000;
            4'hA: return 7'b0100111;
            4'hB: return 7'b0110011;
            4'hC: return 7'b0011101;
            4'hD: return 7'b0010110;
            4'hE: return 7'b0000111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic lzb_dark(input logic [31:0] d, input logic [7:0] p, input int i);
        logic dark;
        dark = 1'b0;
`ifdef SSD_SCAN_LZB_EN
        if (i > 0) begin
            dark = 1'b1;
            for (int j = i; j < 8; j++) begin
                if (((d >> (4 * j)) & 32'hF) != 32'h0 || p[j]) dark = 1'b0;
            end
        end
`endif
        return dark;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starting in a frame-pulse cycle (slot 0 BLANK entered), check the next 80 cycles.
    task automatic check_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        int          i;
        int          c;
        logic        shown;
        logic [7:0]  exp_an;
        logic [6:0]  exp_cc;
        logic        exp_dp;
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            i      = (k - 1) / 10;
            c      = (k - 1) % 10;
            shown  = (c >= 2) && e[i] && !lzb_dark(d, p, i);
            exp_an = shown ? ~(8'h01 << i) : 8'hFF;
            exp_cc = shown ? enc(4'((d >> (4 * i)) & 32'hF)) : 7'h7F;
            exp_dp = shown ? ~p[i] : 1'b1;
            chk($sformatf("an k=%0d", k), 32'(an), 32'(exp_an));
            chk($sformatf("cc k=%0d", k), 32'(cc), 32'(exp_cc));
            chk($sformatf("dp_out k=%0d", k), 32'(dp_out), 32'(exp_dp));
            chk($sformatf("frame k=%0d", k), 32'(frame), 32'(k == 80));
        end
    endtask

    task automatic drive_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        data = d;
        en   = e;
        dp   = p;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        data  = '0;
        dp    = '0;
        en    = '0;
        load  = 1'b0;
        tick(3);
        chk("reset an", 32'(an), 32'hFF);
        chk("reset cc", 32'(cc), 32'h7F);
        chk("reset dp_out", 32'(dp_out), 32'h1);
        chk("reset frame", 32'(frame), 32'h0);
        chk("reset pending", 32'(pending), 32'h0);
        rst_n = 1'b1;

        // Dark display with no load; frame every 80 cycles.
        check_frame(32'h0, 8'h00, 8'h00);
        check_frame(32'h0, 8'h00, 8'h00);

        // Full frame of digits 0..7, decimal point on digit 0.
        drive_load(32'h76543210, 8'hFF, 8'h01);
        chk("t2 pending set", 32'(pending), 32'h1);
        tick(79);
        chk("t2 frame", 32'(frame), 32'h1);
        chk("t2 pending clr", 32'(pending), 32'h0);
        check_frame(32'h76543210, 8'hFF, 8'h01);

        // Lower four digits disabled.
        drive_load(32'h76543210, 8'hF0, 8'h00);
        tick(79);
        chk("t3 frame", 32'(frame), 32'h1);
        check_frame(32'h76543210, 8'hF0, 8'h00);

        // Load at idx 3, then again at idx 5; active frame untouched until the wrap.
        tick(30);
        drive_load(32'h01234567, 8'hFF, 8'h00);
        chk("t4 pending idx3", 32'(pending), 32'h1);
        tick(12);
        chk("t4 an hold", 32'(an), 32'hEF);
        chk("t4 cc hold", 32'(cc), 32'(7'b0011001));
        tick(7);
        drive_load(32'h89ABCDE1, 8'hFF, 8'h80);
        chk("t4 pending idx5", 32'(pending), 32'h1);
        tick(29);
        chk("t4 frame", 32'(frame), 32'h1);
        chk("t4 pending clr", 32'(pending), 32'h0);
        check_frame(32'h89ABCDE1, 8'hFF, 8'h80);

        // Load in the wrap cycle goes straight to the active frame.
        tick(79);
        drive_load(32'h00000305, 8'hFF, 8'h00);
        chk("t4 wrap frame", 32'(frame), 32'h1);
        chk("t4 wrap pending", 32'(pending), 32'h0);
        check_frame(32'h00000305, 8'hFF, 8'h00);

        // Async reset during SHOW of idx 4 with a staged frame pending.
        drive_load(32'h11111111, 8'hFF, 8'hFF);
        tick(44);
        chk("t5 pending before", 32'(pending), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 an async", 32'(an), 32'hFF);
        chk("t5 cc async", 32'(cc), 32'h7F);
        chk("t5 dp_out async", 32'(dp_out), 32'h1);
        chk("t5 frame async", 32'(frame), 32'h0);
        chk("t5 pending async", 32'(pending), 32'h0);
        tick(2);
        rst_n = 1'b1;
        check_frame(32'h0, 8'h00, 8'h00);
        chk("t5 pending after", 32'(pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
